eth_rx_ingress: RTL and testbench

- Per-port receive front end; one instance per switch port (4 total).
- Strips preamble/SFD, streams frame bytes into the port packet FIFO, and captures the 12-byte DST+SRC MAC header into an address buffer.
- Runs CRC-32 over the frame and classifies length and PHY errors.
- Presents an end-of-frame status record that the global switch FSM consumes: IDLE -> FCS_CHECK -> CHECK_ERROR -> MAC_LEARN/PARSE_ADDR or DELETE_PACKET.

---
 rtl/eth_rx_ingress.sv | 133 +++++++++++++
 tb/tb_eth_rx_ingress.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_ingress.sv
// rtl/eth_rx_ingress.sv - per-port receive front end: preamble strip, FIFO write, header capture, CRC-32, status record
module eth_rx_ingress #(
  parameter int DATA_IN_SIZE      = 8,
  parameter int ADDR_BUFFER_DEPTH = 12,
  parameter int MIN_FRAME_LEN     = 64,
  parameter int MAX_FRAME_LEN     = 1518,
  parameter int LEN_W             = 11
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [DATA_IN_SIZE-1:0]                   rx_data,
  input  logic                                      rx_dv,
  input  logic                                      rx_er,
  input  logic                                      fifo_full,
  output logic                                      fifo_wr_en,
  output logic [DATA_IN_SIZE-1:0]                   fifo_wr_data,
  output logic [ADDR_BUFFER_DEPTH*DATA_IN_SIZE-1:0] addr_buf,
  output logic                                      addr_valid,
  output logic                                      status_valid,
  input  logic                                      status_ack,
  output logic                                      fcs_ok,
  output logic [4:0]                                err_flags,
  output logic [LEN_W-1:0]                          frame_len,
  output logic                                      drop_pulse
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, RECV, STATUS, DISCARD} state_t;

  localparam logic [7:0]       PRE_BYTE = 8'h55;
  localparam logic [7:0]       SFD_BYTE = 8'hD5;
  localparam logic [31:0]      CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0]      RESIDUE  = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] LEN_SAT  = '1;

  state_t            state;
  logic [31:0]       crc;
  logic [LEN_W-1:0]  len_inc;
  logic              wr_ok;
  logic              is_pre;

  // Reflected CRC-32, one byte LSB-first
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int b = 0; b < 8; b++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  assign len_inc = (frame_len == LEN_SAT) ? frame_len : frame_len + 1'b1;
  // Once overflow hits, the rest of the frame is dropped so the FIFO never sees a hole
  assign wr_ok   = !err_flags[3] && !fifo_full && (frame_len < LEN_W'(MAX_FRAME_LEN));
  assign is_pre  = (rx_data == PRE_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      crc          <= CRC_INIT;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      addr_buf     <= '0;
      addr_valid   <= 1'b0;
      status_valid <= 1'b0;
      fcs_ok       <= 1'b0;
      err_flags    <= '0;
      frame_len    <= '0;
      drop_pulse   <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_dv) state <= is_pre ? PREAMBLE : DISCARD;
        end
        PREAMBLE: begin
          if (!rx_dv) begin
            state <= status_valid ? STATUS : IDLE;
          end else if (rx_data == SFD_BYTE) begin
            if (status_valid) begin
              state      <= DISCARD;
              drop_pulse <= 1'b1;
            end else begin
              state      <= RECV;
              frame_len  <= '0;
              crc        <= CRC_INIT;
              err_flags  <= '0;
              addr_valid <= 1'b0;
              fcs_ok     <= 1'b0;
            end
          end else if (!is_pre) begin
            state <= DISCARD;
          end
        end
        RECV: begin
          if (rx_dv) begin
            crc          <= crc_byte(crc, rx_data);
            frame_len    <= len_inc;
            fifo_wr_data <= rx_data;
            fifo_wr_en   <= wr_ok;
            if (frame_len < LEN_W'(ADDR_BUFFER_DEPTH)) begin
              addr_buf[(ADDR_BUFFER_DEPTH-1-int'(frame_len))*DATA_IN_SIZE +: DATA_IN_SIZE] <= rx_data;
              if (frame_len == LEN_W'(ADDR_BUFFER_DEPTH-1)) addr_valid <= 1'b1;
            end
            if (rx_er)     err_flags[4] <= 1'b1;
            if (fifo_full) err_flags[3] <= 1'b1;
            if (len_inc == LEN_W'(MAX_FRAME_LEN+1)) err_flags[2] <= 1'b1;
          end else begin
            state        <= STATUS;
            status_valid <= 1'b1;
            fcs_ok       <= (crc == RESIDUE);
            err_flags[1] <= (frame_len < LEN_W'(MIN_FRAME_LEN));
            err_flags[0] <= (crc != RESIDUE);
          end
        end
        STATUS: begin
          // A new preamble may start while the record waits; the SFD check drops it
          if (status_ack) begin
            status_valid <= 1'b0;
            addr_valid   <= 1'b0;
            state        <= rx_dv ? (is_pre ? PREAMBLE : DISCARD) : IDLE;
          end else if (rx_dv) begin
            state <= is_pre ? PREAMBLE : DISCARD;
          end
        end
        DISCARD: begin
          if (!rx_dv) state <= status_valid ? STATUS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_ingress.sv
// tb/tb_eth_rx_ingress.sv - directed self-checking bench for eth_rx_ingress
module tb_eth_rx_ingress;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_dv, rx_er, fifo_full, status_ack;
  logic        fifo_wr_en, addr_valid, status_valid, fcs_ok, drop_pulse;
  logic [7:0]  fifo_wr_data;
  logic [95:0] addr_buf;
  logic [4:0]  err_flags;
  logic [10:0] frame_len;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int drop_cnt = 0;

  logic [7:0]  fr [0:1599];
  logic [95:0] exp_addr;

  eth_rx_ingress dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_dv(rx_dv), .rx_er(rx_er),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .addr_buf(addr_buf), .addr_valid(addr_valid), .status_valid(status_valid),
    .status_ack(status_ack), .fcs_ok(fcs_ok), .err_flags(err_flags),
    .frame_len(frame_len), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_wr_en) wr_cnt++;
    if (drop_pulse) drop_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int b = 0; b < 8; b++)
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  // Payload pattern, then FCS = ~CRC appended LSB byte first; optional bit flip afterwards
  task automatic build(input int n, input int flip_idx);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) begin
      fr[i] = 8'(i * 37 + 11);
      c = crc_step(c, fr[i]);
    end
    c = ~c;
    fr[n-4] = c[7:0];
    fr[n-3] = c[15:8];
    fr[n-2] = c[23:16];
    fr[n-1] = c[31:24];
    if (flip_idx >= 0) fr[flip_idx] = fr[flip_idx] ^ 8'h04;
    exp_addr = '0;
    for (int i = 0; i < 12; i++) exp_addr = {exp_addr[87:0], fr[i]};
  endtask

  task automatic send_frame(input int n, input int full_at, input int er_at);
    for (int p = 0; p < 7; p++) begin
      @(negedge clk); rx_dv = 1'b1; rx_data = 8'h55;
    end
    @(negedge clk); rx_data = 8'hD5;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_data   = fr[i];
      fifo_full = (i == full_at - 1);
      rx_er     = (i == er_at);
    end
    @(negedge clk);
    rx_dv = 1'b0; rx_data = 8'h00; fifo_full = 1'b0; rx_er = 1'b0;
  endtask

  task automatic wait_status();
    int t;
    t = 0;
    while (!status_valid && t < 20) begin
      @(negedge clk); t++;
    end
    chk("status_seen", 128'(status_valid), 128'(1));
  endtask

  task automatic do_ack();
    repeat (3) @(negedge clk);
    status_ack = 1'b1;
    @(negedge clk);
    status_ack = 1'b0;
    chk("ack_status_clr", 128'(status_valid), 128'(0));
    chk("ack_addr_clr", 128'(addr_valid), 128'(0));
  endtask

  task automatic run(input string tag, input int n, input int full_at, input int er_at,
                     input int exp_wr, input logic exp_ok, input logic [4:0] exp_err,
                     input logic exp_av);
    wr_cnt = 0;
    send_frame(n, full_at, er_at);
    wait_status();
    chk({tag, "_writes"}, 128'(wr_cnt), 128'(exp_wr));
    chk({tag, "_fcs_ok"}, 128'(fcs_ok), 128'(exp_ok));
    chk({tag, "_err"}, 128'(err_flags), 128'(exp_err));
    chk({tag, "_len"}, 128'(frame_len), 128'(n));
    chk({tag, "_addr_valid"}, 128'(addr_valid), 128'(exp_av));
    if (exp_av) chk({tag, "_addr_buf"}, 128'(addr_buf), 128'(exp_addr));
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_dv = 1'b0; rx_er = 1'b0;
    fifo_full = 1'b0; status_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        128'({fifo_wr_en, fifo_wr_data, addr_buf, addr_valid, status_valid, fcs_ok,
              err_flags, frame_len, drop_pulse}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    build(64, -1);
    run("good64", 64, -1, -1, 64, 1'b1, 5'b00000, 1'b1);
    do_ack();

    build(64, 20);
    run("badfcs", 64, -1, -1, 64, 1'b0, 5'b00001, 1'b1);
    do_ack();

    build(64, -1);
    run("phy", 64, -1, 5, 64, 1'b1, 5'b10000, 1'b1);
    do_ack();

    build(40, -1);
    run("runt40", 40, -1, -1, 40, 1'b1, 5'b00010, 1'b1);
    do_ack();

    build(8, -1);
    run("runt8", 8, -1, -1, 8, 1'b1, 5'b00010, 1'b0);
    do_ack();

    build(1600, -1);
    run("giant", 1600, -1, -1, 1518, 1'b1, 5'b00100, 1'b1);
    do_ack();

    build(100, -1);
    run("ovf", 100, 20, -1, 19, 1'b1, 5'b01000, 1'b1);
    do_ack();

    // Second frame arrives while the first record is still unacknowledged
    build(64, -1);
    run("first", 64, -1, -1, 64, 1'b1, 5'b00000, 1'b1);
    wr_cnt = 0; drop_cnt = 0;
    send_frame(64, -1, -1);
    repeat (3) @(negedge clk);
    chk("drop_pulses", 128'(drop_cnt), 128'(1));
    chk("drop_writes", 128'(wr_cnt), 128'(0));
    chk("drop_keep_valid", 128'(status_valid), 128'(1));
    chk("drop_keep_rec", 128'({fcs_ok, err_flags, frame_len}), 128'({1'b1, 5'b00000, 11'd64}));
    chk("drop_keep_addr", 128'(addr_buf), 128'(exp_addr));
    do_ack();

    // Asynchronous reset in the middle of a frame
    build(64, -1);
    for (int p = 0; p < 7; p++) begin
      @(negedge clk); rx_dv = 1'b1; rx_data = 8'h55;
    end
    @(negedge clk); rx_data = 8'hD5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); rx_data = fr[i];
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset",
        128'({fifo_wr_en, fifo_wr_data, addr_buf, addr_valid, status_valid, fcs_ok,
              err_flags, frame_len, drop_pulse}), 128'(0));
    @(negedge clk); rx_dv = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run("post_reset", 64, -1, -1, 64, 1'b1, 5'b00000, 1'b1);
    do_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
